// File: rtl/dma_tx_burst_sched_if.sv
// Descriptor, request and completion handshake bundle for dma_tx_burst_sched.
// slave = scheduler side, master = host/fabric side.
`timescale 1ns/1ps
interface dma_tx_burst_sched_if #(
   parameter int RAM_ADDR_WIDTH = 18,
   parameter int BUS_ADDR_WIDTH = 32,
   parameter int DATA_BITS      = 3,
   parameter int USER_TAG_BITS  = 6
) ();
   logic                                   s_desc_valid;
   logic                                   s_desc_ready;
   logic [BUS_ADDR_WIDTH-DATA_BITS-1:0]    s_desc_bus_addr;
   logic [RAM_ADDR_WIDTH-DATA_BITS-1:0]    s_desc_length;

   logic                                   m_rq_valid;
   logic                                   m_rq_ready;
   logic [RAM_ADDR_WIDTH-DATA_BITS:0]      m_rq_loc_addr;
   logic [BUS_ADDR_WIDTH-DATA_BITS-1:0]    m_rq_bus_addr;
   logic [RAM_ADDR_WIDTH-DATA_BITS-1:0]    m_rq_length;
   logic [USER_TAG_BITS-1:0]               m_rq_tag;

   logic                                   s_rc_valid;
   logic                                   s_rc_ready;
   logic [USER_TAG_BITS-1:0]               s_rc_tag;

   modport slave (
      input  s_desc_valid, s_desc_bus_addr, s_desc_length,
      output s_desc_ready,
      output m_rq_valid, m_rq_loc_addr, m_rq_bus_addr, m_rq_length, m_rq_tag,
      input  m_rq_ready,
      input  s_rc_valid, s_rc_tag,
      output s_rc_ready
   );

   modport master (
      output s_desc_valid, s_desc_bus_addr, s_desc_length,
      input  s_desc_ready,
      input  m_rq_valid, m_rq_loc_addr, m_rq_bus_addr, m_rq_length, m_rq_tag,
      output m_rq_ready,
      output s_rc_valid, s_rc_tag,
      input  s_rc_ready
   );
endinterface

// File: rtl/dma_tx_burst_sched.sv
// TX DMA burst scheduler: allocates ring space per descriptor, issues tagged reads,
// retires completions in order. Optional stats via DMA_TX_BURST_SCHED_STATS_EN.
`timescale 1ns/1ps
module dma_tx_burst_sched #(
   parameter int RAM_ADDR_WIDTH  = 18,
   parameter int BUS_ADDR_WIDTH  = 32,
   parameter int DATA_BITS       = 3,
   parameter int USER_TAG_BITS   = 6,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   dma_tx_burst_sched_if.slave               bus,
   input  logic [RAM_ADDR_WIDTH-DATA_BITS:0] s_consume_ram_addr,
   output logic [RAM_ADDR_WIDTH-DATA_BITS:0] m_fill_ram_addr,
   output logic                              busy,
   output logic [15:0]                       m_cpl_cnt,
   output logic                              m_tag_err
);
   localparam int AW   = RAM_ADDR_WIDTH - DATA_BITS;
   localparam int PW   = AW + 1;
   localparam int BW   = BUS_ADDR_WIDTH - DATA_BITS;
   localparam int TW   = USER_TAG_BITS;
   localparam int NTAG = 1 << TW;
   localparam int OW   = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);
   localparam logic [PW-1:0] RING    = {1'b1, {AW{1'b0}}};

   typedef enum logic {IDLE, ISSUE} state_e;

   state_e                   state_q, state_d;
   logic                     run_q, run_d;
   logic [PW-1:0]            alloc_q, alloc_d;
   logic [PW-1:0]            fill_q, fill_d;
   logic [TW-1:0]            next_tag_q, next_tag_d;
   logic [TW-1:0]            head_q, head_d;
   logic [OW-1:0]            out_q, out_d;
   logic [NTAG-1:0]          pend_q, pend_d;
   logic [NTAG-1:0]          done_q, done_d;
   logic [NTAG-1:0][PW-1:0]  end_tab_q, end_tab_d;
   logic [PW-1:0]            rq_loc_q, rq_loc_d;
   logic [BW-1:0]            rq_bus_q, rq_bus_d;
   logic [AW-1:0]            rq_len_q, rq_len_d;
   logic [TW-1:0]            rq_tag_q, rq_tag_d;

   logic [PW-1:0] used, free, need, alloc_nxt;
   logic          desc_rdy, accept, rc_fire, rc_good, retire;

   // Modular distance handles the wrap bit; free can reach exactly RING.
   assign used      = alloc_q - s_consume_ram_addr;
   assign free      = RING - used;
   assign need      = {1'b0, bus.s_desc_length} + PW'(1);
   assign alloc_nxt = alloc_q + need;
   assign desc_rdy  = run_q && (state_q == IDLE) && (out_q < MAX_OUT) && (need <= free);
   assign accept    = desc_rdy && bus.s_desc_valid;
   assign rc_fire   = run_q && bus.s_rc_valid;
   assign rc_good   = pend_q[bus.s_rc_tag] && !done_q[bus.s_rc_tag];
   assign retire    = done_q[head_q];

   always_comb begin
      state_d    = state_q;
      run_d      = 1'b1;
      alloc_d    = alloc_q;
      fill_d     = fill_q;
      next_tag_d = next_tag_q;
      head_d     = head_q;
      out_d      = out_q;
      pend_d     = pend_q;
      done_d     = done_q;
      end_tab_d  = end_tab_q;
      rq_loc_d   = rq_loc_q;
      rq_bus_d   = rq_bus_q;
      rq_len_d   = rq_len_q;
      rq_tag_d   = rq_tag_q;

      case (state_q)
         IDLE: if (accept) begin
            state_d  = ISSUE;
            rq_loc_d = alloc_q;
            rq_bus_d = bus.s_desc_bus_addr;
            rq_len_d = bus.s_desc_length;
            rq_tag_d = next_tag_q;
            alloc_d  = alloc_nxt;
         end
         ISSUE: if (bus.m_rq_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (retire) begin
         fill_d         = end_tab_q[head_q];
         pend_d[head_q] = 1'b0;
         done_d[head_q] = 1'b0;
         head_d         = head_q + TW'(1);
      end

      // next_tag never aliases a retiring head: either outstanding is 0 or head is in flight.
      if (accept) begin
         end_tab_d[next_tag_q] = alloc_nxt;
         pend_d[next_tag_q]    = 1'b1;
         next_tag_d            = next_tag_q + TW'(1);
      end

      if (rc_fire && rc_good) done_d[bus.s_rc_tag] = 1'b1;

      case ({accept, retire})
         2'b10:   out_d = out_q + OW'(1);
         2'b01:   out_d = out_q - OW'(1);
         default: out_d = out_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         run_q      <= 1'b0;
         alloc_q    <= '0;
         fill_q     <= '0;
         next_tag_q <= '0;
         head_q     <= '0;
         out_q      <= '0;
         pend_q     <= '0;
         done_q     <= '0;
         end_tab_q  <= '0;
         rq_loc_q   <= '0;
         rq_bus_q   <= '0;
         rq_len_q   <= '0;
         rq_tag_q   <= '0;
      end else begin
         state_q    <= state_d;
         run_q      <= run_d;
         alloc_q    <= alloc_d;
         fill_q     <= fill_d;
         next_tag_q <= next_tag_d;
         head_q     <= head_d;
         out_q      <= out_d;
         pend_q     <= pend_d;
         done_q     <= done_d;
         end_tab_q  <= end_tab_d;
         rq_loc_q   <= rq_loc_d;
         rq_bus_q   <= rq_bus_d;
         rq_len_q   <= rq_len_d;
         rq_tag_q   <= rq_tag_d;
      end
   end

`ifdef DMA_TX_BURST_SCHED_STATS_EN
   logic [15:0] cpl_cnt_q, cpl_cnt_d;
   logic        tag_err_q, tag_err_d;

   always_comb begin
      cpl_cnt_d = cpl_cnt_q;
      tag_err_d = tag_err_q;
      if (retire) cpl_cnt_d = cpl_cnt_q + 16'd1;
      if (rc_fire && !rc_good) tag_err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cpl_cnt_q <= '0;
         tag_err_q <= 1'b0;
      end else begin
         cpl_cnt_q <= cpl_cnt_d;
         tag_err_q <= tag_err_d;
      end
   end

   assign m_cpl_cnt = cpl_cnt_q;
   assign m_tag_err = tag_err_q;
`else
   assign m_cpl_cnt = '0;
   assign m_tag_err = 1'b0;
`endif

   assign bus.s_desc_ready  = desc_rdy;
   assign bus.m_rq_valid    = (state_q == ISSUE);
   assign bus.m_rq_loc_addr = rq_loc_q;
   assign bus.m_rq_bus_addr = rq_bus_q;
   assign bus.m_rq_length   = rq_len_q;
   assign bus.m_rq_tag      = rq_tag_q;
   assign bus.s_rc_ready    = run_q;
   assign m_fill_ram_addr   = fill_q;
   assign busy              = (out_q != '0) || (state_q == ISSUE);
endmodule

// File: tb/tb_dma_tx_burst_sched.sv
// Bench for dma_tx_burst_sched with a 512-word ring (RAM_ADDR_WIDTH 12): request
// scoreboard, free-space vector table, and directed ordering/limit/reset sequences.
`timescale 1ns/1ps
module tb_dma_tx_burst_sched;
   localparam int RAW = 12;
   localparam int BAW = 32;
   localparam int DB  = 3;
   localparam int TGB = 6;
   localparam int MO  = 4;
   localparam int AW  = RAW - DB;
   localparam int PW  = AW + 1;
   localparam int BW  = BAW - DB;
`ifdef DMA_TX_BURST_SCHED_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [PW-1:0] consume = '0;
   logic [PW-1:0] fill;
   logic          busy;
   logic [15:0]   cpl_cnt;
   logic          tag_err;

   dma_tx_burst_sched_if #(.RAM_ADDR_WIDTH(RAW), .BUS_ADDR_WIDTH(BAW), .DATA_BITS(DB),
                           .USER_TAG_BITS(TGB)) bus_if ();

   dma_tx_burst_sched #(.RAM_ADDR_WIDTH(RAW), .BUS_ADDR_WIDTH(BAW), .DATA_BITS(DB),
                        .USER_TAG_BITS(TGB), .MAX_OUTSTANDING(MO)) dut (
      .clk(clk), .rst(rst), .bus(bus_if), .s_consume_ram_addr(consume),
      .m_fill_ram_addr(fill), .busy(busy), .m_cpl_cnt(cpl_cnt), .m_tag_err(tag_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [PW-1:0]  loc;
      logic [BW-1:0]  baddr;
      logic [AW-1:0]  len;
      logic [TGB-1:0] tag;
   } rq_t;
   rq_t sb[$];

   typedef struct {
      logic [PW-1:0] cons;
      logic [AW-1:0] len;
      logic          rdy;
   } vec_t;
   vec_t vecs[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Scoreboard: expected request pushed at descriptor handshake, popped at request handshake.
   initial begin
      logic [PW-1:0]  mdl_alloc;
      logic [TGB-1:0] mdl_tag;
      rq_t e, r;
      mdl_alloc = '0;
      mdl_tag   = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            sb.delete();
            mdl_alloc = '0;
            mdl_tag   = '0;
         end else begin
            if (bus_if.s_desc_valid && bus_if.s_desc_ready) begin
               e.loc   = mdl_alloc;
               e.baddr = bus_if.s_desc_bus_addr;
               e.len   = bus_if.s_desc_length;
               e.tag   = mdl_tag;
               sb.push_back(e);
               mdl_alloc = mdl_alloc + PW'(bus_if.s_desc_length) + PW'(1);
               mdl_tag   = mdl_tag + TGB'(1);
            end
            if (bus_if.m_rq_valid && bus_if.m_rq_ready) begin
               if (sb.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL rq_unexpected: tag %0h", bus_if.m_rq_tag);
               end else begin
                  r = sb.pop_front();
                  chk("sb_loc", bus_if.m_rq_loc_addr, r.loc);
                  chk("sb_bus", bus_if.m_rq_bus_addr, r.baddr);
                  chk("sb_len", bus_if.m_rq_length, r.len);
                  chk("sb_tag", bus_if.m_rq_tag, r.tag);
               end
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      bus_if.s_desc_valid    = 1'b0;
      bus_if.s_desc_bus_addr = '0;
      bus_if.s_desc_length   = '0;
      bus_if.s_rc_valid      = 1'b0;
      bus_if.s_rc_tag        = '0;
      bus_if.m_rq_ready      = 1'b1;
      consume = '0;
      cyc(2);
      rst = 1'b1;
      #1;
      chk("rel_rc_ready_0", bus_if.s_rc_ready, 1'b0);
      chk("rel_desc_ready_0", bus_if.s_desc_ready, 1'b0);
      cyc(1);
      chk("rel_desc_ready_1", bus_if.s_desc_ready, 1'b1);
   endtask

   task automatic send_desc(input logic [BW-1:0] ba, input logic [AW-1:0] len);
      bit ok;
      ok = 1'b0;
      bus_if.s_desc_bus_addr = ba;
      bus_if.s_desc_length   = len;
      bus_if.s_desc_valid    = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus_if.s_desc_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      bus_if.s_desc_valid = 1'b0;
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL desc_timeout: bus %0h never accepted", ba);
      end
   endtask

   task automatic send_cpl(input logic [TGB-1:0] t);
      bus_if.s_rc_valid = 1'b1;
      bus_if.s_rc_tag   = t;
      cyc(1);
      bus_if.s_rc_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // After one 64-word descriptor: alloc 64, nothing outstanding.
      vecs[0] = '{cons: 10'd64,  len: 9'd511, rdy: 1'b1};
      vecs[1] = '{cons: 10'd0,   len: 9'd447, rdy: 1'b1};
      vecs[2] = '{cons: 10'd0,   len: 9'd448, rdy: 1'b0};
      vecs[3] = '{cons: 10'd32,  len: 9'd479, rdy: 1'b1};
      vecs[4] = '{cons: 10'd32,  len: 9'd480, rdy: 1'b0};
      vecs[5] = '{cons: 10'd64,  len: 9'd0,   rdy: 1'b1};

      bus_if.s_desc_valid    = 1'b0;
      bus_if.s_desc_bus_addr = '0;
      bus_if.s_desc_length   = '0;
      bus_if.s_rc_valid      = 1'b0;
      bus_if.s_rc_tag        = '0;
      bus_if.m_rq_ready      = 1'b1;
      #3;
      chk("rst_desc_ready", bus_if.s_desc_ready, 1'b0);
      chk("rst_rq_valid", bus_if.m_rq_valid, 1'b0);
      chk("rst_rc_ready", bus_if.s_rc_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_fill", fill, 10'd0);
      chk("rst_cpl", cpl_cnt, 16'd0);
      chk("rst_err", tag_err, 1'b0);

      // Single descriptor
      do_reset();
      send_desc(29'h1000, 9'd63);
      chk("s1_rq_valid", bus_if.m_rq_valid, 1'b1);
      chk("s1_loc", bus_if.m_rq_loc_addr, 10'd0);
      chk("s1_tag", bus_if.m_rq_tag, 6'd0);
      chk("s1_len", bus_if.m_rq_length, 9'd63);
      cyc(1);
      chk("s1_rq_drop", bus_if.m_rq_valid, 1'b0);
      chk("s1_busy", busy, 1'b1);
      send_cpl(6'd0);
      chk("s1_fill_lat", fill, 10'd0);
      cyc(1);
      chk("s1_fill", fill, 10'd64);
      chk("s1_cpl", cpl_cnt, STATS ? 16'd1 : 16'd0);
      chk("s1_busy_done", busy, 1'b0);

      for (int i = 0; i < 6; i++) begin
         consume = vecs[i].cons;
         bus_if.s_desc_length = vecs[i].len;
         #1;
         chk($sformatf("vec%0d_ready", i), bus_if.s_desc_ready, vecs[i].rdy);
      end

      // Out-of-order completion 2,0,3,1
      do_reset();
      for (int i = 0; i < 4; i++) send_desc(BW'(29'h2000 + i * 16), 9'd127);
      cyc(2);
      send_cpl(6'd2);
      cyc(1);
      chk("s2_hold", fill, 10'd0);
      send_cpl(6'd0);
      cyc(1);
      chk("s2_fill0", fill, 10'd128);
      send_cpl(6'd3);
      cyc(1);
      chk("s2_hold3", fill, 10'd128);
      send_cpl(6'd1);
      chk("s2_lat1", fill, 10'd128);
      cyc(1);
      chk("s2_fill1", fill, 10'd256);
      cyc(1);
      chk("s2_fill2", fill, 10'd384);
      cyc(1);
      chk("s2_fill3", fill, 10'd512);
      chk("s2_cpl", cpl_cnt, STATS ? 16'd4 : 16'd0);
      chk("s2_busy", busy, 1'b0);

      // Ring full then wrap
      do_reset();
      send_desc(29'h3000, 9'd255);
      send_desc(29'h3100, 9'd255);
      cyc(1);
      bus_if.s_desc_bus_addr = 29'h3200;
      bus_if.s_desc_length   = 9'd255;
      bus_if.s_desc_valid    = 1'b1;
      #1;
      chk("s3_full", bus_if.s_desc_ready, 1'b0);
      cyc(2);
      chk("s3_full_hold", bus_if.s_desc_ready, 1'b0);
      send_cpl(6'd0);
      cyc(1);
      chk("s3_fill", fill, 10'd256);
      chk("s3_still_full", bus_if.s_desc_ready, 1'b0);
      consume = 10'd256;
      #1;
      chk("s3_room", bus_if.s_desc_ready, 1'b1);
      cyc(1);
      bus_if.s_desc_valid = 1'b0;
      chk("s3_wrap_loc", bus_if.m_rq_loc_addr, 10'h200);
      chk("s3_wrap_tag", bus_if.m_rq_tag, 6'd2);
      cyc(1);
      send_cpl(6'd1);
      send_cpl(6'd2);
      cyc(2);
      chk("s3_fill_end", fill, 10'h300);
      chk("s3_busy", busy, 1'b0);

      // Outstanding limit, simultaneous accept+retire, completion during retirement
      do_reset();
      for (int i = 0; i < 4; i++) send_desc(BW'(29'h5000 + i * 2), 9'd15);
      cyc(1);
      bus_if.s_desc_bus_addr = 29'h5100;
      bus_if.s_desc_length   = 9'd15;
      bus_if.s_desc_valid    = 1'b1;
      #1;
      chk("s5_limit", bus_if.s_desc_ready, 1'b0);
      cyc(3);
      chk("s5_limit_hold", bus_if.s_desc_ready, 1'b0);
      send_cpl(6'd0);
      chk("s5_limit_pre", bus_if.s_desc_ready, 1'b0);
      cyc(1);
      chk("s5_limit_open", bus_if.s_desc_ready, 1'b1);
      cyc(1);
      bus_if.s_desc_valid = 1'b0;
      chk("s5_tag4", bus_if.m_rq_tag, 6'd4);
      cyc(1);
      fork
         send_desc(29'h5200, 9'd15);
         begin
            send_cpl(6'd1);
            send_cpl(6'd2);
         end
      join
      cyc(2);
      send_cpl(6'd3);
      send_cpl(6'd4);
      cyc(2);
      chk("s5_busy_one", busy, 1'b1);
      chk("s5_fill_mid", fill, 10'd80);
      send_cpl(6'd5);
      cyc(2);
      chk("s5_busy_zero", busy, 1'b0);
      chk("s5_fill_end", fill, 10'd96);
      chk("s5_cpl", cpl_cnt, STATS ? 16'd6 : 16'd0);

      // Bad completions
      do_reset();
      send_cpl(6'd5);
      chk("s4_err_nopend", tag_err, STATS);
      chk("s4_fill_nopend", fill, 10'd0);
      do_reset();
      send_desc(29'h4000, 9'd7);
      send_desc(29'h4010, 9'd7);
      cyc(1);
      send_cpl(6'd1);
      chk("s4_err_clean", tag_err, 1'b0);
      send_cpl(6'd1);
      chk("s4_err_dup", tag_err, STATS);
      send_cpl(6'd0);
      cyc(2);
      chk("s4_fill", fill, 10'd16);
      send_cpl(6'd0);
      cyc(2);
      chk("s4_fill_dup", fill, 10'd16);
      chk("s4_cpl", cpl_cnt, STATS ? 16'd2 : 16'd0);
      chk("s4_busy", busy, 1'b0);

      // Reset mid-operation
      do_reset();
      send_desc(29'h6000, 9'd31);
      cyc(1);
      bus_if.m_rq_ready = 1'b0;
      send_desc(29'h6100, 9'd31);
      cyc(2);
      chk("s6_pre_valid", bus_if.m_rq_valid, 1'b1);
      chk("s6_pre_busy", busy, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      chk("s6_rq_valid", bus_if.m_rq_valid, 1'b0);
      chk("s6_busy", busy, 1'b0);
      chk("s6_rc_ready", bus_if.s_rc_ready, 1'b0);
      chk("s6_desc_ready", bus_if.s_desc_ready, 1'b0);
      chk("s6_rq_loc", bus_if.m_rq_loc_addr, 10'd0);
      cyc(2);
      bus_if.m_rq_ready = 1'b1;
      rst = 1'b1;
      cyc(1);
      send_desc(29'h7000, 9'd15);
      chk("s6_new_tag", bus_if.m_rq_tag, 6'd0);
      chk("s6_new_loc", bus_if.m_rq_loc_addr, 10'd0);
      cyc(4);
      chk("s6_no_stale", fill, 10'd0);
      send_cpl(6'd0);
      cyc(1);
      chk("s6_fill", fill, 10'd16);
      chk("s6_busy_end", busy, 1'b0);

      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
